// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) on a start/ready handshake.
// Returns {remainder, quotient}; annul_i aborts an in-flight division.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CALC    = 2'd1;
  localparam logic [1:0] DIVZERO = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    abs_a   = neg_if(signed_div_i & opdata1_i[WIDTH-1], opdata1_i);
    abs_b   = neg_if(signed_div_i & opdata2_i[WIDTH-1], opdata2_i);
    // rem < dvs always holds, so one extra bit is enough for the shifted value
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    borrow  = trial[WIDTH];
  end

  assign ready_o = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r <= signed_div_i & opdata1_i[WIDTH-1];
            dvs   <= abs_b;
            rem   <= '0;
            cnt   <= '0;
            // the raw dividend is kept for the divide-by-zero result
            if (opdata2_i == '0) begin
              quo   <= opdata1_i;
              state <= DIVZERO;
            end else begin
              quo   <= abs_a;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (annul_i) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            result_o <= {neg_if(neg_r, rem), neg_if(neg_q, quo)};
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            rem <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~borrow};
          end
        end
        DIVZERO: begin
          result_o <= {quo, {WIDTH{1'b1}}};
          state    <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a scoreboard queue holds expected results and
// the cycle at which each ready pulse must appear.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] last_exp = 64'd0;

  div_iter #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sgn),
    .opdata1_i    (a),
    .opdata2_i    (b),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] ux, uy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    ux = (s && x[31]) ? (32'd0 - x) : x;
    uy = (s && y[31]) ? (32'd0 - y) : y;
    q  = ux / uy;
    r  = ux % uy;
    if (s && (x[31] ^ y[31])) q = 32'd0 - q;
    if (s && x[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Every ready pulse must match the head of the scoreboard, on its due cycle.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        cur = sb.pop_front();
        chk("result", result, cur.res);
        chk("ready_cycle", 64'(cyc), 64'(cur.due));
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [63:0] exp);
    bit ok;
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{res: exp, due: cyc + ((y == 32'd0) ? 1 : 33)});
    last_exp = exp;
    wait_ready(ok);
    if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    start = 1'b0;
  endtask

  initial begin
    bit          ok;
    int          n;
    logic [31:0] rx, ry;
    logic        rs;

    rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
    do_div(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF});
    do_div(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF});
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0});

    for (int i = 0; i < 4; i++) begin
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 28);
      rs = 1'($urandom_range(0, 1));
      do_div(rx, ry, rs, model(rx, ry, rs));
    end

    // annul at CALC iteration 10: no pulse, result holds
    @(negedge clk);
    a = 32'd50; b = 32'd5; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n + 10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    repeat (40) @(negedge clk);
    chk("annul_hold", result, last_exp);
    do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

    // annul beats start in IDLE
    @(negedge clk);
    a = 32'd77; b = 32'd5; start = 1'b1; annul = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; annul = 1'b0;
    repeat (40) @(negedge clk);
    chk("annul_idle_hold", result, last_exp);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop_reset_result", result, 64'd0);
    chk("midop_reset_ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div(32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF});

    // back-to-back: start held through ready, second accepted in the following IDLE
    @(negedge clk);
    a = 32'd20; b = 32'd6; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    sb.push_back('{res: {32'd2, 32'd3}, due: n + 33});
    sb.push_back('{res: {32'd6, 32'd142}, due: n + 68});
    a = 32'd1000; b = 32'd7;
    wait_ready(ok);
    if (!ok) chk("b2b_first_timeout", 64'd0, 64'd1);
    wait_ready(ok);
    if (!ok) chk("b2b_second_timeout", 64'd0, 64'd1);
    start = 1'b0;

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
